intt_pass_sequencer: RTL and testbench

// - Upstream controller for iNTTControl_v1. Accepts one inverse-NTT job per valid/ready handshake and splits it into
//   per-pass commands (NTT_levels <= logE, NTT_base_level), highest levels first.
// - Pulses start_NTT once per pass and waits for NTT_working to rise and then fall.
// - Toggles the ping-pong buffer bank between passes. Pulses job_done at the end, or raises error on a stalled pass.

---
 rtl/intt_pass_sequencer_pkg.sv | 30 +++
 rtl/intt_pass_sequencer_splitter.sv | 21 ++
 rtl/intt_pass_sequencer.sv | 113 +++++++++++
 tb/tb_intt_pass_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intt_pass_sequencer_pkg.sv
// Shared types and constants for the inverse-NTT pass sequencer.
package intt_pass_sequencer_pkg;

  localparam int LOGE  = 3;
  localparam int LOGN  = 10;
  localparam int FSIZE = 32;
  localparam int N     = 1 << LOGN;

  localparam int INTT_SEQ_START_TMO = 8;
  localparam int INTT_SEQ_TIMEOUT   = N;

  // Level fields are sized so that LOGE and MAX_LEVELS themselves are representable.
  localparam int LVL_W  = $clog2(LOGE + 1);
  localparam int BASE_W = $clog2(LOGN);
  localparam int TOT_W  = $clog2(LOGN + 1);
  localparam int TMR_W  = $clog2(INTT_SEQ_TIMEOUT + 1);

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT_BUSY,
    SEQ_WAIT_DONE
  } intt_seq_state_e;

  typedef struct packed {
    logic [LVL_W-1:0]  levels;
    logic [BASE_W-1:0] base_level;
  } intt_pass_cmd_t;

endpackage

// File: rtl/intt_pass_sequencer_splitter.sv
// Combinational pass split: takes up to LOGE of the remaining levels from the top.
module intt_pass_sequencer_splitter
  import intt_pass_sequencer_pkg::*;
(
  input  logic [TOT_W-1:0] rem,
  output intt_pass_cmd_t   cmd,
  output logic [TOT_W-1:0] rem_next
);

  localparam logic [TOT_W-1:0] LOGE_T = TOT_W'(LOGE);

  logic [TOT_W-1:0] lv;

  always_comb begin
    lv             = (rem < LOGE_T) ? rem : LOGE_T;
    rem_next       = rem - lv;
    cmd.levels     = LVL_W'(lv);
    cmd.base_level = BASE_W'(rem_next);
  end

endmodule

// File: rtl/intt_pass_sequencer.sv
// Splits one inverse-NTT job into per-pass commands for iNTTControl_v1, highest levels first.
//  state          | meaning
//  SEQ_IDLE       | job_ready high; error holds the outcome of the last job
//  SEQ_ISSUE      | start_NTT pulse; pass command already registered
//  SEQ_WAIT_BUSY  | waiting for NTT_working to rise (start timeout)
//  SEQ_WAIT_DONE  | pass running; waiting for NTT_working to fall (pass timeout)
module intt_pass_sequencer
  import intt_pass_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [FSIZE-1:0]  job_p,
  input  logic [TOT_W-1:0]  job_total_levels,
  output logic              start_NTT,
  output logic [FSIZE-1:0]  p,
  output logic [LVL_W-1:0]  NTT_levels,
  output logic [BASE_W-1:0] NTT_base_level,
  input  logic              NTT_working,
  output logic              bank_sel,
  output logic              job_done,
  output logic              error
);

  intt_seq_state_e  state, state_nxt;
  intt_pass_cmd_t   cmd;
  logic [TOT_W-1:0] rem, split_in, rem_next;
  logic [TMR_W-1:0] tmr;
  logic             job_legal, accept, busy_tmo, done_tmo, pass_end, last_pass, load_cmd;

  assign job_legal = (job_total_levels != '0) && (job_total_levels <= TOT_W'(LOGN));
  assign accept    = (state == SEQ_IDLE) && job_valid;
  assign last_pass = (rem == '0);
  assign pass_end  = (state == SEQ_WAIT_DONE) && !NTT_working;
  assign busy_tmo  = (state == SEQ_WAIT_BUSY) && !NTT_working && (tmr == '0);
  assign done_tmo  = (state == SEQ_WAIT_DONE) && NTT_working && (tmr == '0);
  assign load_cmd  = (accept && job_legal) || (pass_end && !last_pass);

  // The first pass splits straight from the request so the command is ready in ISSUE.
  assign split_in  = (state == SEQ_IDLE) ? job_total_levels : rem;

  intt_pass_sequencer_splitter u_split (
    .rem      (split_in),
    .cmd      (cmd),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= SEQ_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE:      if (accept && job_legal) state_nxt = SEQ_ISSUE;
      SEQ_ISSUE:     state_nxt = SEQ_WAIT_BUSY;
      SEQ_WAIT_BUSY: if (NTT_working)   state_nxt = SEQ_WAIT_DONE;
                     else if (busy_tmo) state_nxt = SEQ_IDLE;
      SEQ_WAIT_DONE: if (pass_end)      state_nxt = last_pass ? SEQ_IDLE : SEQ_ISSUE;
                     else if (done_tmo) state_nxt = SEQ_IDLE;
      default:       state_nxt = SEQ_IDLE;
    endcase
  end

  always_comb begin
    job_ready = (state == SEQ_IDLE);
    start_NTT = (state == SEQ_ISSUE);
  end

  // Down-counter parks at zero, so a stalled pass can never wrap into a fake completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr <= '0;
    end else begin
      case (state)
        SEQ_ISSUE:     tmr <= TMR_W'(INTT_SEQ_START_TMO);
        SEQ_WAIT_BUSY: if (NTT_working)     tmr <= TMR_W'(INTT_SEQ_TIMEOUT);
                       else if (tmr != '0)  tmr <= tmr - TMR_W'(1);
        SEQ_WAIT_DONE: if (tmr != '0)       tmr <= tmr - TMR_W'(1);
        default:       tmr <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p              <= '0;
      rem            <= '0;
      NTT_levels     <= '0;
      NTT_base_level <= '0;
      bank_sel       <= 1'b0;
      job_done       <= 1'b0;
      error          <= 1'b0;
    end else begin
      job_done <= pass_end && last_pass;
      if (accept) begin
        error <= !job_legal;
        if (job_legal) p <= job_p;
      end else if (busy_tmo || done_tmo) begin
        error <= 1'b1;
      end
      if (load_cmd) begin
        NTT_levels     <= cmd.levels;
        NTT_base_level <= cmd.base_level;
        rem            <= rem_next;
      end
      if (pass_end && !last_pass) bank_sel <= ~bank_sel;
    end
  end

endmodule

// File: tb/tb_intt_pass_sequencer.sv
// Bench for intt_pass_sequencer: job-level model checked every cycle plus directed literal checks.
module tb_intt_pass_sequencer;
  import intt_pass_sequencer_pkg::*;

  logic              clk, rstn, job_valid, job_ready, start_NTT, NTT_working;
  logic              bank_sel, job_done, error;
  logic [FSIZE-1:0]  job_p, p;
  logic [TOT_W-1:0]  job_total_levels;
  logic [LVL_W-1:0]  NTT_levels;
  logic [BASE_W-1:0] NTT_base_level;

  intt_pass_sequencer dut (
    .clk              (clk),
    .rstn             (rstn),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_p            (job_p),
    .job_total_levels (job_total_levels),
    .start_NTT        (start_NTT),
    .p                (p),
    .NTT_levels       (NTT_levels),
    .NTT_base_level   (NTT_base_level),
    .NTT_working      (NTT_working),
    .bank_sel         (bank_sel),
    .job_done         (job_done),
    .error            (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // iNTTControl_v1 stand-in: rises rise_dly cycles after start_NTT, stays busy busy_len cycles.
  bit rise_en = 1'b1;
  bit stuck   = 1'b0;
  int rise_dly = 2;
  int busy_len = 20;
  int rcnt = 0, bcnt = 0;
  bit was_stuck = 1'b0;

  initial begin
    NTT_working = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        NTT_working = 1'b0; rcnt = 0; bcnt = 0;
      end else if (stuck) begin
        NTT_working = 1'b1; was_stuck = 1'b1;
      end else if (was_stuck) begin
        NTT_working = 1'b0; was_stuck = 1'b0;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) NTT_working = 1'b0;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin NTT_working = 1'b1; bcnt = busy_len; end
      end else if (start_NTT && rise_en) begin
        rcnt = rise_dly;
      end
    end
  end

  // Job-level reference model: pass list from plain arithmetic, timeouts as cycle counts.
  bit          m_busy, m_err, m_bank, e_start, e_done, n_start, n_done;
  int          m_phase, m_wait, m_run, m_lv, m_base;
  logic [31:0] m_p;
  int          q_lv[$], q_base[$];
  int          st_lv[$], st_base[$], st_bank[$], st_cyc[$], done_cyc[$];
  int          err_cyc = 0;
  bit          err_prev = 1'b0;

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_bank = 0; m_p = '0; m_lv = 0; m_base = 0;
    m_phase = 0; m_wait = 0; m_run = 0; e_start = 0; e_done = 0;
    q_lv.delete(); q_base.delete();
  endtask

  task automatic plan(input int total);
    int r = total;
    int lv;
    q_lv.delete(); q_base.delete();
    while (r > 0) begin
      lv = (r < LOGE) ? r : LOGE;
      r -= lv;
      q_lv.push_back(lv);
      q_base.push_back(r);
    end
  endtask

  task automatic model_abort();
    m_err = 1; m_busy = 0; m_phase = 0;
    q_lv.delete(); q_base.delete();
  endtask

  initial begin : compare
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) model_reset();
      chk("job_ready", job_ready, !m_busy);
      chk("start_NTT", start_NTT, e_start);
      chk("job_done", job_done, e_done);
      chk("error", error, m_err);
      chk("bank_sel", bank_sel, m_bank);
      chk("p", p, m_p);
      chk("NTT_levels", NTT_levels, m_lv);
      chk("NTT_base_level", NTT_base_level, m_base);
      if (start_NTT) begin
        st_lv.push_back(int'(NTT_levels)); st_base.push_back(int'(NTT_base_level));
        st_bank.push_back(int'(bank_sel)); st_cyc.push_back(cyc);
      end
      if (job_done) done_cyc.push_back(cyc);
      if (error && !err_prev) err_cyc = cyc;
      err_prev = error;
      if (rstn) begin
        n_start = 0; n_done = 0;
        if (!m_busy) begin
          if (job_valid) begin
            if (job_total_levels == 0 || int'(job_total_levels) > LOGN) m_err = 1;
            else begin
              m_err = 0; m_p = job_p; plan(int'(job_total_levels));
              m_busy = 1; n_start = 1;
            end
          end
        end else if (m_phase == 0) begin
          m_phase = 1; m_wait = 0;
        end else if (m_phase == 1) begin
          if (NTT_working) begin m_phase = 2; m_run = 0; end
          else begin
            m_wait++;
            if (m_wait > INTT_SEQ_START_TMO) model_abort();
          end
        end else begin
          if (!NTT_working) begin
            m_phase = 0;
            if (q_lv.size() == 0) begin n_done = 1; m_busy = 0; end
            else begin n_start = 1; m_bank = !m_bank; end
          end else begin
            m_run++;
            if (m_run > INTT_SEQ_TIMEOUT) model_abort();
          end
        end
        if (n_start) begin
          m_lv = q_lv.pop_front();
          m_base = q_base.pop_front();
        end
        e_start = n_start; e_done = n_done;
      end
    end
  end

  task automatic submit(input int tot, input logic [31:0] pv);
    @(posedge clk); #1;
    job_valid = 1'b1; job_total_levels = TOT_W'(tot); job_p = pv;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (job_done !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    chk("job_done_within_bound", n < bound, 1);
  endtask

  task automatic wait_err(input int bound);
    int n = 0;
    while (error !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    chk("error_within_bound", n < bound, 1);
  endtask

  task automatic wait_starts(input int count, input int bound);
    int n = 0;
    while (st_lv.size() < count && n < bound) begin @(negedge clk); n++; end
    chk("starts_within_bound", n < bound, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b, d;
    int exp_lv[4];
    int exp_base[4];
    exp_lv   = '{3, 3, 3, 1};
    exp_base = '{7, 4, 1, 0};
    rstn = 1'b1; job_valid = 1'b0; job_p = '0; job_total_levels = '0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_job_ready", job_ready, 1);
    chk("reset_error", error, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // 10 levels in 4 passes
    b = st_lv.size(); d = done_cyc.size();
    submit(10, 32'h1234_5678);
    wait_done(300);
    @(posedge clk); #1;
    chk("job10_pass_count", st_lv.size() - b, 4);
    if (st_lv.size() == b + 4)
      for (int i = 0; i < 4; i++) begin
        chk("job10_levels", st_lv[b+i], exp_lv[i]);
        chk("job10_base", st_base[b+i], exp_base[i]);
        chk("job10_bank", st_bank[b+i], i & 1);
      end
    chk("job10_done_count", done_cyc.size() - d, 1);
    chk("job10_p", p, 32'h1234_5678);

    // single pass; bank stays at 1
    b = st_lv.size(); d = done_cyc.size();
    submit(3, 32'h0000_0777);
    wait_done(100);
    @(posedge clk); #1;
    chk("job3_pass_count", st_lv.size() - b, 1);
    if (st_lv.size() == b + 1 && done_cyc.size() == d + 1) begin
      chk("job3_levels", st_lv[b], 3);
      chk("job3_base", st_base[b], 0);
      chk("job3_bank", st_bank[b], 1);
      chk("job3_start_to_done", done_cyc[d] - st_cyc[b], 23);
    end
    chk("job3_bank_after", bank_sel, 1);

    // illegal totals
    b = st_lv.size();
    submit(0, 32'hDEAD_0000);
    repeat (2) @(negedge clk);
    chk("total0_error", error, 1);
    chk("total0_ready", job_ready, 1);
    submit(LOGN + 1, 32'hDEAD_0001);
    repeat (2) @(negedge clk);
    chk("total11_error", error, 1);
    chk("total11_ready", job_ready, 1);
    chk("illegal_no_start", st_lv.size() - b, 0);
    submit(1, 32'h0000_0001);
    @(negedge clk);
    chk("legal_clears_error", error, 0);
    wait_done(100);

    // NTT_working never rises
    rise_en = 1'b0;
    b = st_lv.size();
    submit(6, 32'h0000_0006);
    wait_err(100);
    @(posedge clk); #1;
    if (st_lv.size() == b + 1) chk("start_tmo_latency", err_cyc - st_cyc[b], 10);
    chk("start_tmo_ready", job_ready, 1);
    rise_en = 1'b1;

    // NTT_working stuck high, already high while idle
    stuck = 1'b1;
    b = st_lv.size();
    repeat (3) @(posedge clk);
    submit(3, 32'h0000_0003);
    wait_err(1200);
    @(posedge clk); #1;
    if (st_lv.size() == b + 1) chk("pass_tmo_latency", err_cyc - st_cyc[b], 1027);
    stuck = 1'b0;
    repeat (3) @(posedge clk);

    // back-to-back jobs with job_valid held
    b = st_lv.size(); d = done_cyc.size();
    @(posedge clk); #1;
    job_valid = 1'b1; job_total_levels = TOT_W'(2); job_p = 32'hAAAA_0001;
    @(posedge clk); #1;
    job_total_levels = TOT_W'(4); job_p = 32'hBBBB_0002;
    wait_done(100);
    @(posedge clk); #1;
    job_valid = 1'b0;
    wait_starts(b + 2, 20);
    @(negedge clk);
    chk("b2b_p_updated", p, 32'hBBBB_0002);
    if (st_lv.size() >= b + 2 && done_cyc.size() >= d + 1) begin
      chk("b2b_done_to_start", st_cyc[b+1] - done_cyc[d], 1);
      chk("b2b_levels", st_lv[b+1], 3);
      chk("b2b_base", st_base[b+1], 1);
    end
    wait_done(200);

    // reset during pass 2 of 4
    repeat (2) @(posedge clk);
    b = st_lv.size();
    submit(10, 32'h5555_AAAA);
    wait_starts(b + 2, 100);
    repeat (5) @(posedge clk);
    d = done_cyc.size();
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("abort_bank_sel", bank_sel, 0);
    chk("abort_levels", NTT_levels, 0);
    chk("abort_base", NTT_base_level, 0);
    chk("abort_p", p, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (30) @(posedge clk);
    chk("abort_no_done", done_cyc.size() - d, 0);
    b = st_lv.size();
    submit(10, 32'h0F0F_0F0F);
    wait_starts(b + 1, 20);
    @(posedge clk); #1;
    if (st_lv.size() >= b + 1) begin
      chk("restart_levels", st_lv[b], 3);
      chk("restart_base", st_base[b], 7);
      chk("restart_bank", st_bank[b], 0);
    end
    wait_done(300);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
